// File: rtl/gblur_pkg.sv
// gblur_pkg -- shared definitions for the streaming 3x3 Gaussian blur.
//
// Contents:
//   - RGB565 field widths and LSB positions
//   - per-channel accumulator widths
//   - kernel tap weights ([1 2 1; 2 4 2; 1 2 1], normalised by 16)
//   - rounding constant and shift
//   - frame FSM state enum
package gblur_pkg;

    localparam int PIX_W = 16;

    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int R_LSB = 11;
    localparam int G_LSB = 5;
    localparam int B_LSB = 0;

    // Worst case is 16 * channel max, which fits these widths even after
    // the rounding constant is added.
    localparam int R_SUM_W = 9;
    localparam int G_SUM_W = 10;
    localparam int B_SUM_W = 9;

    localparam int ROUND_ADD   = 8;
    localparam int ROUND_SHIFT = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    // Tap index is row*3 + col. The weight is the product of the
    // separable 1-2-1 factors.
    function automatic int tap_weight(input int idx);
        int r;
        int c;
        r = idx / 3;
        c = idx % 3;
        return ((r == 1) ? 2 : 1) * ((c == 1) ? 2 : 1);
    endfunction

endpackage

// File: rtl/gblur_kernel3x3.sv
// gblur_kernel3x3 -- combinational 3x3 Gaussian blur of one RGB565 window.
//
// Ports:
//   win  in  9 x 16 : window pixels, index row*3 + col (row 0 = top)
//   pix  out 16     : blurred pixel, each channel (sum + 8) >> 4
module gblur_kernel3x3
    import gblur_pkg::*;
(
    input  logic [8:0][PIX_W-1:0] win,
    output logic [PIX_W-1:0]      pix
);

    logic [R_SUM_W-1:0] sum_r;
    logic [G_SUM_W-1:0] sum_g;
    logic [B_SUM_W-1:0] sum_b;

    always_comb begin
        sum_r = '0;
        sum_g = '0;
        sum_b = '0;
        for (int i = 0; i < 9; i++) begin
            sum_r = sum_r + R_SUM_W'(tap_weight(i)) * R_SUM_W'(win[i][R_LSB +: R_W]);
            sum_g = sum_g + G_SUM_W'(tap_weight(i)) * G_SUM_W'(win[i][G_LSB +: G_W]);
            sum_b = sum_b + B_SUM_W'(tap_weight(i)) * B_SUM_W'(win[i][B_LSB +: B_W]);
        end
        pix = {R_W'((sum_r + R_SUM_W'(ROUND_ADD)) >> ROUND_SHIFT),
               G_W'((sum_g + G_SUM_W'(ROUND_ADD)) >> ROUND_SHIFT),
               B_W'((sum_b + B_SUM_W'(ROUND_ADD)) >> ROUND_SHIFT)};
    end

endmodule

// File: rtl/gaussian_blur_stream.sv
// gaussian_blur_stream -- streaming 3x3 Gaussian blur for RGB565 frames.
//
// Parameters: IMG_W, IMG_H (frame size, each >= 3).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start / done        : frame start (IDLE only) / one-cycle end pulse
//   s_valid/s_ready/s_data : input pixel stream, raster order
//   m_valid/m_ready/m_data : blurred pixel stream, raster order
//
// Build option: define GBLUR_EDGE_REPLICATE_EN to blur border pixels with
// clamped (replicated) neighbours; otherwise border pixels pass through.
//
// Datapath: an input at (cx,cy) reads column cx of both line buffers
// (rows cy-1, cy-2), forming a new window column with the input pixel.
// Together with the two previous columns this yields output (cx-1,cy-1).
// The column-end input also completes (W-1,cy-1), which is held as a
// "pending" output and loaded on the next free output slot. In FLUSH the
// last row is replayed from the line buffers as virtual inputs.
module gaussian_blur_stream
    import gblur_pkg::*;
#(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             done,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H + 2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    // Input row value while replaying the last row; output row value once
    // every output has been loaded.
    localparam logic [RW-1:0] ROW_END  = RW'(IMG_H);

    state_t state_reg, state_next;
    logic [CW-1:0] in_col_reg, in_col_next, out_col_reg, out_col_next;
    logic [RW-1:0] in_row_reg, in_row_next, out_row_reg, out_row_next;
    logic pend_reg, pend_next;
    logic m_valid_reg;
    logic [PIX_W-1:0] m_data_reg;

    logic free, accept, flush_step, step, step_out, pend_load, load, last_out;

    logic [PIX_W-1:0] lb_a [IMG_W];   // row cy-1 at the current column
    logic [PIX_W-1:0] lb_b [IMG_W];   // row cy-2 at the current column
    logic [PIX_W-1:0] lb_a_rd, lb_b_rd;

    // Window columns, element 0 = top row, 2 = bottom row.
    logic [2:0][PIX_W-1:0] col_l_reg, col_c_reg, col_new;
    logic [2:0][2:0][PIX_W-1:0] cols;
    logic [8:0][PIX_W-1:0] win;
    logic [PIX_W-1:0] kern_pix, out_pix;

    // Handshakes. A pending output only exists right after a column-end
    // input, so the next input is column 0, which completes no output and
    // can be accepted on the same edge the pending output loads.
    assign free       = !m_valid_reg || m_ready;
    assign s_ready    = (state_reg == RUN) && free;
    assign accept     = s_valid && s_ready;
    assign flush_step = (state_reg == FLUSH) && free && (in_row_reg == ROW_END);
    assign step       = accept || flush_step;
    assign step_out   = step && (in_col_reg != '0) && (in_row_reg != '0);
    assign pend_load  = pend_reg && free;
    assign load       = step_out || pend_load;
    assign last_out   = (state_reg == FLUSH) && m_valid_reg && m_ready
                        && (out_row_reg == ROW_END);

    always_comb begin
        state_next = state_reg;
        done       = 1'b0;
        unique case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && in_col_reg == COL_LAST && in_row_reg == ROW_LAST)
                         state_next = FLUSH;
            FLUSH:   if (last_out) state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_col_next  = in_col_reg;
        in_row_next  = in_row_reg;
        out_col_next = out_col_reg;
        out_row_next = out_row_reg;
        pend_next    = pend_reg;
        if (step) begin
            if (in_col_reg == COL_LAST) begin
                in_col_next = '0;
                in_row_next = in_row_reg + RW'(1);
            end else begin
                in_col_next = in_col_reg + CW'(1);
            end
        end
        if (load) begin
            if (out_col_reg == COL_LAST) begin
                out_col_next = '0;
                out_row_next = out_row_reg + RW'(1);
            end else begin
                out_col_next = out_col_reg + CW'(1);
            end
        end
        if (step && in_col_reg == COL_LAST && in_row_reg != '0)
            pend_next = 1'b1;
        else if (pend_load)
            pend_next = 1'b0;
        if (state_reg == DONE) begin
            in_col_next  = '0;
            in_row_next  = '0;
            out_col_next = '0;
            out_row_next = '0;
            pend_next    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            in_col_reg  <= '0;
            in_row_reg  <= '0;
            out_col_reg <= '0;
            out_row_reg <= '0;
            pend_reg    <= 1'b0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            col_l_reg   <= '0;
            col_c_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            in_col_reg  <= in_col_next;
            in_row_reg  <= in_row_next;
            out_col_reg <= out_col_next;
            out_row_reg <= out_row_next;
            pend_reg    <= pend_next;
            if (load) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= out_pix;
            end else if (m_ready) begin
                m_valid_reg <= 1'b0;
            end
            if (step) begin
                col_l_reg <= col_c_reg;
                col_c_reg <= col_new;
            end
        end
    end

    // Line buffers. The read address tracks the column of the next input,
    // so the registered read data is ready when that input arrives.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_a[in_col_reg] <= s_data;
            lb_b[in_col_reg] <= lb_a_rd;
        end
        lb_a_rd <= lb_a[in_col_next];
        lb_b_rd <= lb_b[in_col_next];
    end

    // In FLUSH the bottom entry (s_data) is junk; it is always clamped away
    // because the output row is then H-1.
    assign col_new[0] = lb_b_rd;
    assign col_new[1] = lb_a_rd;
    assign col_new[2] = s_data;

    // Clamp out-of-frame neighbours to the nearest in-frame pixel.
    always_comb begin
        cols[0] = col_l_reg;
        cols[1] = col_c_reg;
        cols[2] = col_new;
        if (out_col_reg == '0)      cols[0] = col_c_reg;
        if (out_col_reg == COL_LAST) cols[2] = col_c_reg;
        for (int c = 0; c < 3; c++) begin
            if (out_row_reg == '0)      cols[c][0] = cols[c][1];
            if (out_row_reg == ROW_LAST) cols[c][2] = cols[c][1];
        end
    end

    for (genvar gi = 0; gi < 9; gi++) begin : g_win
        assign win[gi] = cols[gi % 3][gi / 3];
    end

    gblur_kernel3x3 u_kernel (
        .win (win),
        .pix (kern_pix)
    );

`ifdef GBLUR_EDGE_REPLICATE_EN
    assign out_pix = kern_pix;
`else
    logic on_border;
    assign on_border = (out_col_reg == '0) || (out_col_reg == COL_LAST)
                    || (out_row_reg == '0) || (out_row_reg == ROW_LAST);
    assign out_pix = on_border ? col_c_reg[1] : kern_pix;
`endif

    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;

endmodule

// File: tb/tb_gaussian_blur_stream.sv
// tb_gaussian_blur_stream -- randomized self-checking bench for
// gaussian_blur_stream on an 8x6 frame. Expected pixels come from a
// direct per-pixel convolution of the stored input frame.
module tb_gaussian_blur_stream;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst, start, done;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [15:0] s_data, m_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] img [NPIX];
    logic [15:0] got [NPIX];

    always #5 clk = ~clk;

    gaussian_blur_stream #(.IMG_W(W), .IMG_H(H)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .done    (done),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
        end
    endtask

    function automatic logic [15:0] ref_pix(input int x, input int y);
        int sr, sg, sb, xx, yy, wgt;
        logic [15:0] p;
        sr = 0;
        sg = 0;
        sb = 0;
`ifndef GBLUR_EDGE_REPLICATE_EN
        if (x == 0 || y == 0 || x == W - 1 || y == H - 1) return img[y * W + x];
`endif
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                xx = x + dx;
                yy = y + dy;
                if (xx < 0) xx = 0;
                if (xx > W - 1) xx = W - 1;
                if (yy < 0) yy = 0;
                if (yy > H - 1) yy = H - 1;
                wgt = ((dx == 0) ? 2 : 1) * ((dy == 0) ? 2 : 1);
                p = img[yy * W + xx];
                sr += wgt * int'(p[15:11]);
                sg += wgt * int'(p[10:5]);
                sb += wgt * int'(p[4:0]);
            end
        end
        return {5'((sr + 8) / 16), 6'((sg + 8) / 16), 5'((sb + 8) / 16)};
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) img[i] = 16'($urandom);
    endtask

    task automatic fill_const(input logic [15:0] v);
        for (int i = 0; i < NPIX; i++) img[i] = v;
    endtask

    // Runs one frame: drives inputs on the falling edge, samples 1 ns later.
    // abort_n > 0 resets the block once that many inputs were accepted.
    task automatic run_frame(input string name, input int vprob, input int rprob,
                             input bit mid_start, input int abort_n);
        int n_in, n_out, n_done, cyc, tail, first_in, last_in;
        bit stall;
        logic [15:0] held;
        n_in = 0; n_out = 0; n_done = 0; cyc = 0; tail = 0;
        first_in = -1; last_in = 0; stall = 1'b0; held = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 3000 && tail < 4) begin
            s_valid = (n_in < NPIX) && ($urandom_range(99) < vprob);
            s_data  = (n_in < NPIX) ? img[n_in] : 16'h0;
            m_ready = ($urandom_range(99) < rprob);
            start   = mid_start && (cyc == 10);
            #1;
            if (done) n_done++;
            if (stall) begin
                check({name, " hold_valid"}, 32'(m_valid), 32'd1);
                check({name, " hold_data"}, 32'(m_data), 32'(held));
            end
            stall = m_valid && !m_ready;
            held  = m_data;
            if (m_valid && m_ready) begin
                if (n_out < NPIX) begin
                    got[n_out] = m_data;
                    check($sformatf("%s pix(%0d,%0d)", name, n_out % W, n_out / W),
                          32'(m_data), 32'(ref_pix(n_out % W, n_out / W)));
                end
                n_out++;
            end
            if (s_valid && s_ready) begin
                if (first_in < 0) first_in = cyc;
                last_in = cyc;
                n_in++;
            end
            if (abort_n > 0 && n_in >= abort_n) break;
            if (n_done > 0) tail++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (abort_n > 0) begin
            @(negedge clk);
            rst     = 1'b1;
            s_valid = 1'b0;
            @(negedge clk);
            #1;
            check({name, " rst s_ready"}, 32'(s_ready), 32'd0);
            check({name, " rst m_valid"}, 32'(m_valid), 32'd0);
            check({name, " rst m_data"}, 32'(m_data), 32'd0);
            check({name, " rst done"}, 32'(done), 32'd0);
            rst = 1'b0;
            $display("frame %s: aborted after %0d inputs", name, n_in);
        end else begin
            s_valid = 1'b0;
            check({name, " out_count"}, 32'(n_out), 32'(NPIX));
            check({name, " done_count"}, 32'(n_done), 32'd1);
            if (vprob == 100 && rprob == 100)
                check({name, " throughput"}, 32'(last_in - first_in), 32'(NPIX - 1));
            $display("frame %s: %0d inputs, %0d outputs, %0d cycles", name, n_in, n_out, cyc);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset s_ready", 32'(s_ready), 32'd0);
        check("reset m_valid", 32'(m_valid), 32'd0);
        check("reset m_data", 32'(m_data), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst = 1'b0;

        fill_const(16'hFFFF);
        run_frame("uniform", 100, 100, 1'b0, 0);
        check("uniform first", 32'(got[0]), 32'hFFFF);
        check("uniform last", 32'(got[NPIX - 1]), 32'hFFFF);

        fill_const(16'h0000);
        img[3 * W + 3] = 16'hF800;
        run_frame("red", 100, 100, 1'b0, 0);
        check("red centre", 32'(got[3 * W + 3]), 32'h4000);
        check("red west", 32'(got[3 * W + 2]), 32'h2000);
        check("red north", 32'(got[2 * W + 3]), 32'h2000);
        check("red diag", 32'(got[2 * W + 2]), 32'h1000);
        check("red far", 32'(got[0]), 32'h0000);

        fill_const(16'h0000);
        img[0] = 16'h001F;
        run_frame("blue", 100, 70, 1'b0, 0);
        check("blue diag", 32'(got[W + 1]), 32'h0002);
`ifdef GBLUR_EDGE_REPLICATE_EN
        check("blue corner", 32'(got[0]), 32'h0011);
        check("blue east", 32'(got[1]), 32'h0006);
`else
        check("blue corner", 32'(got[0]), 32'h001F);
        check("blue east", 32'(got[1]), 32'h0000);
`endif

        for (int k = 0; k < 4; k++) begin
            fill_random();
            run_frame($sformatf("rand%0d", k), 40 + $urandom_range(60),
                      30 + $urandom_range(70), 1'b0, 0);
        end

        fill_random();
        run_frame("abort", 80, 80, 1'b0, 20);
        fill_random();
        run_frame("after_abort", 70, 50, 1'b0, 0);

        fill_random();
        run_frame("midstart", 90, 90, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
